display_scan: RTL and testbench
===============================

Name: display_scan

Overview:
- Consumer end of the panel data buses: `matrixData` (8x8 two-colour RG pixels) and `numbersData` (8 hex nibbles).
- Time-multiplexes both onto the physical 8-digit 7-segment display and the 8x8 bicolour LED matrix. The two displays share one slot counter.
- Input buses are snapshotted once per frame, so producers may change them at any time without tearing.
- Sits between the panel-content modules (self-test, game logic) and the board pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per slot; must be >= 4.
- BLANK, 4, dead cycles at the start of each slot with all enables off (anti-ghosting); must satisfy 1 <= BLANK < SCAN_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- matrixData  in  128  pixel p = row*8+col; bit [2p+1] = R, bit [2p] = G.
- numbersData  in  32  digit i = bits [4i+3:4i]; digit 7 = [31:28] = leftmost.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dig_sel  out  8  digit enable, active-low; bit i = digit i.
- row_sel  out  8  matrix row enable, active-low; bit r = row r.
- col_r  out  8  red column drive, active-high; bit c = column c.
- col_g  out  8  green column drive, active-high; bit c = column c.
- frame_sync  out  1  1-cycle pulse on the cycle the snapshot is loaded.

Behaviour:
- Counters:
  - cnt runs 0..SCAN_DIV-1 and wraps to 0.
  - slot (3 bits) increments when cnt wraps; 7 -> 0.
- Snapshot:
  - num_snap and mat_snap load from the inputs on the cycle where cnt==SCAN_DIV-1 and slot==7.
  - frame_sync is high on the following cycle (the first cycle of slot 0) only.
  - Input changes at any other cycle have no effect until the next snapshot.
- Outputs are registered. The value in cycle n+1 is a function of cnt, slot and the snapshot in cycle n (latency 1).
- Blank phase (cnt < BLANK):
  - dig_sel=8'hFF, row_sel=8'hFF, col_r=0, col_g=0, seg=7'h7F.
- Active phase (cnt >= BLANK):
  - dig_sel = ~(1<<slot).
  - seg = decode(num_snap digit slot).
  - row_sel = ~(1<<slot).
  - col_r[c] = R bit of pixel(slot,c); col_g[c] = G bit of pixel(slot,c).
- Decode table (active-low, hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06
  - F:7F, i.e. nibble F means blank digit (producers use F to hide).
- Matrix colours:
  - RG=11 (yellow) drives both col_r and col_g.
  - RG=00 drives neither.
- Reset (synchronous; applies from the cycle after rst is sampled high):
  - cnt=0, slot=0.
  - num_snap=32'hFFFFFFFF (all blank), mat_snap=0.
  - All outputs in blank state; frame_sync=0.
- Reset mid-slot:
  - Scan restarts at slot 0 with cnt=0.
  - Old snapshot is discarded; the display stays dark until the first snapshot at the end of the first frame.
- At most one dig_sel bit and one row_sel bit is low in any cycle.
- No enable is ever low during the blank phase, including across the slot 7->0 wrap.
- Frame period = 8*SCAN_DIV cycles.

Test Plan:
(bench parameters: SCAN_DIV=8, BLANK=2)
- Reset, then hold numbersData=32'h76543210 -> after the first frame_sync, slot i active cycles show dig_sel=~(1<<i) and seg=decode(i). For example, slot 0 gives seg=7'h40 and slot 7 gives seg=7'h78.
- numbersData=32'h0FFFFFF8 -> digit 0 seg=7'h00; digits 1..6 seg=7'h7F with dig_sel still strobed; digit 7 seg=7'h40.
- matrixData = {64{2'b10}}, then {64{2'b11}}, each held one frame -> first frame col_r=8'hFF, col_g=8'h00 on every row; next frame col_r=8'hFF, col_g=8'hFF.
  - Single pixel (row 3, col 5) = 01 -> only in slot 3: col_g=8'h20, col_r=0.
- Change numbersData at slot 4, cnt 3 -> displayed digits do not change until after the next frame_sync; frame_sync pulses exactly every 64 cycles.
- Check every cycle -> cnt<2 gives all enables high and columns 0; never more than one dig_sel/row_sel bit low.
- Assert rst for 1 cycle during slot 5 -> next cycle all outputs blank with slot=0; seg=7'h7F in every active phase until the first frame_sync 64 cycles later.

Source files
------------

// File: rtl/display_scan_if.sv
// Panel data bus between content producers and the display scanner.
// Producers drive the pixel/digit buses; the scanner drives the board-pin outputs.
interface display_scan_if;
    logic [127:0] matrixData;
    logic [31:0]  numbersData;
    logic [6:0]   seg;
    logic [7:0]   dig_sel;
    logic [7:0]   row_sel;
    logic [7:0]   col_r;
    logic [7:0]   col_g;
    logic         frame_sync;

    modport master (
        output matrixData, numbersData,
        input  seg, dig_sel, row_sel, col_r, col_g, frame_sync
    );

    modport slave (
        input  matrixData, numbersData,
        output seg, dig_sel, row_sel, col_r, col_g, frame_sync
    );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed scanner for the 8-digit 7-segment display and 8x8 bicolour matrix.
// Both displays share one slot counter; inputs are snapshotted once per frame.
module display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 4
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       slot, slot_next;
    logic [31:0]      num_snap;
    logic [127:0]     mat_snap;
    logic             slot_end, frame_end;

    logic [6:0]  seg_q, seg_d;
    logic [7:0]  dig_q, dig_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic        fs_q;
    logic [15:0] row_bits;
    logic [3:0]  nibble;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Outputs are computed from the counter values the next cycle will hold, so the
    // registered drive lines up with cnt/slot and the blank window is honoured at every wrap.
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (slot == 3'd7);
        cnt_next  = slot_end ? '0 : cnt + 1'b1;
        slot_next = slot_end ? slot + 3'd1 : slot;
        row_bits  = mat_snap[{slot_next, 4'b0000} +: 16];
        nibble    = num_snap[{slot_next, 2'b00} +: 4];

        seg_d = 7'h7F;
        dig_d = 8'hFF;
        row_d = 8'hFF;
        r_d   = 8'h00;
        g_d   = 8'h00;
        if (cnt_next >= CNT_BLANK) begin
            seg_d = seg_decode(nibble);
            dig_d = ~(8'd1 << slot_next);
            row_d = ~(8'd1 << slot_next);
            for (int c = 0; c < 8; c++) begin
                r_d[c] = row_bits[2*c+1];
                g_d[c] = row_bits[2*c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            slot     <= 3'd0;
            num_snap <= 32'hFFFF_FFFF;
            mat_snap <= '0;
            seg_q    <= 7'h7F;
            dig_q    <= 8'hFF;
            row_q    <= 8'hFF;
            r_q      <= 8'h00;
            g_q      <= 8'h00;
            fs_q     <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            slot  <= slot_next;
            seg_q <= seg_d;
            dig_q <= dig_d;
            row_q <= row_d;
            r_q   <= r_d;
            g_q   <= g_d;
            fs_q  <= frame_end;
            if (frame_end) begin
                num_snap <= bus.numbersData;
                mat_snap <= bus.matrixData;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.row_sel    = row_q;
    assign bus.col_r      = r_q;
    assign bus.col_g      = g_q;
    assign bus.frame_sync = fs_q;
endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a cycle model pushes expected pin states,
// a negedge checker pops and compares them against the DUT.
module tb_display_scan;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = 8 * SCAN_DIV;

    typedef struct {
        logic [6:0]  seg;
        logic [7:0]  dig;
        logic [7:0]  row;
        logic [7:0]  r;
        logic [7:0]  g;
        logic        fs;
        int unsigned t;
    } exp_t;

    logic clk;
    logic rst;
    display_scan_if bus();

    display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

    bit          armed = 0;
    int          mcnt = 0;
    int          mslot = 0;
    int unsigned mt = 0;
    bit          mfs = 0;
    logic [31:0]  snap_num = '1;
    logic [127:0] snap_mat = '0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] nums, input logic [127:0] mat, input int cycles);
        bus.numbersData = nums;
        bus.matrixData  = mat;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: advances the spec counters at each edge and predicts the pins for the new cycle.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            armed    = 1;
            mcnt     = 0;
            mslot    = 0;
            mt       = 0;
            mfs      = 0;
            snap_num = '1;
            snap_mat = '0;
        end else if (armed) begin
            mfs = (mcnt == SCAN_DIV - 1) && (mslot == 7);
            if (mfs) begin
                snap_num = bus.numbersData;
                snap_mat = bus.matrixData;
            end
            if (mcnt == SCAN_DIV - 1) begin
                mcnt  = 0;
                mslot = (mslot + 1) % 8;
            end else begin
                mcnt++;
            end
            mt++;
        end
        if (armed) begin
            e.fs = mfs;
            e.t  = mt;
            if (mcnt < BLANK) begin
                e.seg = 7'h7F; e.dig = 8'hFF; e.row = 8'hFF; e.r = 8'h00; e.g = 8'h00;
            end else begin
                e.seg = seg_tab[snap_num[4*mslot +: 4]];
                e.dig = ~(8'd1 << mslot);
                e.row = ~(8'd1 << mslot);
                for (int c = 0; c < 8; c++) begin
                    e.r[c] = snap_mat[2*(mslot*8+c)+1];
                    e.g[c] = snap_mat[2*(mslot*8+c)];
                end
            end
            sb.push_back(e);
        end
    end

    int cyc = 0;
    int last_fs_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("seg", {25'd0, bus.seg}, {25'd0, e.seg});
            checkOutput("dig_sel", {24'd0, bus.dig_sel}, {24'd0, e.dig});
            checkOutput("row_sel", {24'd0, bus.row_sel}, {24'd0, e.row});
            checkOutput("col_r", {24'd0, bus.col_r}, {24'd0, e.r});
            checkOutput("col_g", {24'd0, bus.col_g}, {24'd0, e.g});
            checkOutput("frame_sync", {31'd0, bus.frame_sync}, {31'd0, e.fs});
            checkOutput("dig_onehot", {31'd0, ($countones(~bus.dig_sel) <= 1)}, 32'd1);
            checkOutput("row_onehot", {31'd0, ($countones(~bus.row_sel) <= 1)}, 32'd1);
            if (e.t == 0) last_fs_cyc = cyc;
            if (bus.frame_sync === 1'b1) begin
                checkOutput("fs_gap", cyc - last_fs_cyc, FRAME);
                last_fs_cyc = cyc;
            end
        end
    end

    initial begin
        logic [127:0] pix;
        int i;

        rst = 1'b1;
        bus.numbersData = '0;
        bus.matrixData  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus(32'h7654_3210, '0, 2 * FRAME);
        applyStimulus(32'h0FFF_FFF8, '0, 2 * FRAME);
        applyStimulus(32'h0FFF_FFF8, {64{2'b10}}, FRAME);
        applyStimulus(32'h0FFF_FFF8, {64{2'b11}}, FRAME);

        pix = '0;
        pix[2*(3*8+5)] = 1'b1;
        applyStimulus(32'h7654_3210, pix, 2 * FRAME);

        // Change digits mid-frame; the model only picks them up at the next snapshot.
        for (i = 0; i < 2 * FRAME && !(mslot == 4 && mcnt == 3); i++) @(negedge clk);
        checkOutput("wait_slot4", {26'd0, mslot[2:0], mcnt[2:0]}, {26'd0, 3'd4, 3'd3});
        applyStimulus(32'hABCD_E012, pix, 2 * FRAME);

        // One-cycle reset during slot 5.
        for (i = 0; i < 2 * FRAME && !(mslot == 5 && mcnt == 4); i++) @(negedge clk);
        checkOutput("wait_slot5", {26'd0, mslot[2:0], mcnt[2:0]}, {26'd0, 3'd5, 3'd4});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h7654_3210, {64{2'b01}}, 2 * FRAME + 4);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
